// File: rtl/rob_ctrl_pkg.sv
// Shared types for the in-order commit controller (reorder buffer).
// Build option: define ROB_FULL_BYPASS_EN to reuse the retiring slot when full.
package rob_ctrl_pkg;

   localparam int ROB_SIZE          = 16;
   localparam int ROB_IDX_BITS      = $clog2(ROB_SIZE);
   localparam int STORE_BUFFER_SIZE = 8;
   localparam int SB_IDX_BITS       = $clog2(STORE_BUFFER_SIZE);

   typedef logic [ROB_IDX_BITS-1:0] rob_idx_t;
   typedef logic [ROB_IDX_BITS:0]   rob_cnt_t;
   typedef logic [SB_IDX_BITS-1:0]  store_buffer_idx_t;
   typedef logic [31:0]             instruction_t;

   typedef struct packed {
      logic              valid;
      logic              completed;
      logic              branch_taken;
      logic [31:0]       pc;
      instruction_t      instr;
      logic [4:0]        rd;
      logic              we;
      logic              store;
      store_buffer_idx_t sb_idx;
      logic [31:0]       kanata_id;
      logic [31:0]       result;
      logic [31:0]       new_pc;
   } rob_entry_t;

   function automatic rob_cnt_t rob_cnt_next(
      input rob_cnt_t cnt,
      input logic     inc,
      input logic     dec
   );
      rob_cnt_t nxt;
      nxt = cnt;
      if (inc && !dec)
         nxt = cnt + rob_cnt_t'(1);
      else if (dec && !inc)
         nxt = cnt - rob_cnt_t'(1);
      return nxt;
   endfunction

endpackage

// File: rtl/rob_ctrl_if.sv
// Decode/WB/commit bundle of the reorder buffer.
// master = pipeline side, slave = rob_ctrl.
interface rob_ctrl_if;
   import rob_ctrl_pkg::*;

   logic              alloc_valid_i;
   logic              alloc_ready_o;
   rob_idx_t          alloc_idx_o;
   logic [31:0]       alloc_pc_i;
   instruction_t      alloc_instr_i;
   logic [4:0]        alloc_rd_i;
   logic              alloc_we_i;
   logic              alloc_store_i;
   store_buffer_idx_t alloc_sb_idx_i;
   logic [31:0]       alloc_kanata_id_i;

   logic              complete_valid_i;
   rob_idx_t          complete_idx_i;
   logic [31:0]       complete_result_i;
   logic              complete_branch_taken_i;
   logic [31:0]       complete_new_pc_i;

   logic              commit_valid_o;
   logic [4:0]        commit_rd_o;
   logic              commit_we_o;
   logic [31:0]       commit_result_o;
   logic              commit_store_o;
   store_buffer_idx_t commit_sb_idx_o;
   logic [31:0]       commit_kanata_id_o;
   logic              flush_o;
   logic [31:0]       flush_pc_o;
   rob_cnt_t          count_o;

   modport master (
      output alloc_valid_i, alloc_pc_i, alloc_instr_i,
      output alloc_rd_i, alloc_we_i, alloc_store_i,
      output alloc_sb_idx_i, alloc_kanata_id_i,
      output complete_valid_i, complete_idx_i,
      output complete_result_i, complete_branch_taken_i,
      output complete_new_pc_i,
      input  alloc_ready_o, alloc_idx_o,
      input  commit_valid_o, commit_rd_o, commit_we_o,
      input  commit_result_o, commit_store_o,
      input  commit_sb_idx_o, commit_kanata_id_o,
      input  flush_o, flush_pc_o, count_o
   );

   modport slave (
      input  alloc_valid_i, alloc_pc_i, alloc_instr_i,
      input  alloc_rd_i, alloc_we_i, alloc_store_i,
      input  alloc_sb_idx_i, alloc_kanata_id_i,
      input  complete_valid_i, complete_idx_i,
      input  complete_result_i, complete_branch_taken_i,
      input  complete_new_pc_i,
      output alloc_ready_o, alloc_idx_o,
      output commit_valid_o, commit_rd_o, commit_we_o,
      output commit_result_o, commit_store_o,
      output commit_sb_idx_o, commit_kanata_id_o,
      output flush_o, flush_pc_o, count_o
   );

endinterface

// File: rtl/rob_ptr_ctr.sv
// Wrap-around ROB pointer with increment and synchronous clear.
module rob_ptr_ctr
   import rob_ctrl_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     inc,
   input  logic     clr,
   output rob_idx_t ptr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (clr)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + rob_idx_t'(1);
   end

endmodule

// File: rtl/rob_ctrl.sv
// In-order commit controller: circular ROB with alloc, completion, commit, flush.
// Build option: ROB_FULL_BYPASS_EN lets a full ROB accept into the retiring slot.
module rob_ctrl
   import rob_ctrl_pkg::*;
(
   input  logic      clk_i,
   input  logic      rstn_i,
   rob_ctrl_if.slave rob
);

   rob_entry_t ent_q [ROB_SIZE];
   rob_entry_t head_ent;
   rob_entry_t new_ent;
   rob_idx_t   head;
   rob_idx_t   tail;
   rob_cnt_t   count_q;

   logic empty;
   logic full;
   logic commit;
   logic flush;
   logic alloc_rdy;
   logic alloc_fire;
   logic comp_hit;
   logic unused_trace;

   assign head_ent = ent_q[head];
   assign empty    = (count_q == '0);
   assign full     = (count_q == rob_cnt_t'(ROB_SIZE));
   assign commit   = !empty && head_ent.valid && head_ent.completed;
   assign flush    = commit && head_ent.branch_taken;

`ifdef ROB_FULL_BYPASS_EN
   assign alloc_rdy = rstn_i && !flush && (!full || commit);
`else
   assign alloc_rdy = rstn_i && !flush && !full;
`endif

   assign alloc_fire = rob.alloc_valid_i && alloc_rdy;
   assign comp_hit   = rob.complete_valid_i
                    && ent_q[rob.complete_idx_i].valid;

   // pc/instr ride along for trace and debug visibility only
   assign unused_trace = ^{head_ent.pc, head_ent.instr};

   always_comb begin
      new_ent           = '0;
      new_ent.valid     = 1'b1;
      new_ent.pc        = rob.alloc_pc_i;
      new_ent.instr     = rob.alloc_instr_i;
      new_ent.rd        = rob.alloc_rd_i;
      new_ent.we        = rob.alloc_we_i;
      new_ent.store     = rob.alloc_store_i;
      new_ent.sb_idx    = rob.alloc_sb_idx_i;
      new_ent.kanata_id = rob.alloc_kanata_id_i;
   end

   rob_ptr_ctr u_head (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .inc   (commit),
      .clr   (flush),
      .ptr   (head)
   );

   rob_ptr_ctr u_tail (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .inc   (alloc_fire),
      .clr   (flush),
      .ptr   (tail)
   );

   // alloc is written last so a full-bypass reuse of head wins over its clear
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < ROB_SIZE; i++)
            ent_q[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            ent_q[i].valid     <= 1'b0;
            ent_q[i].completed <= 1'b0;
         end
      end else begin
         if (commit)
            ent_q[head].valid <= 1'b0;
         if (comp_hit) begin
            ent_q[rob.complete_idx_i].completed    <= 1'b1;
            ent_q[rob.complete_idx_i].result       <= rob.complete_result_i;
            ent_q[rob.complete_idx_i].branch_taken <= rob.complete_branch_taken_i;
            ent_q[rob.complete_idx_i].new_pc       <= rob.complete_new_pc_i;
         end
         if (alloc_fire)
            ent_q[tail] <= new_ent;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         count_q <= '0;
      else if (flush)
         count_q <= '0;
      else
         count_q <= rob_cnt_next(count_q, alloc_fire, commit);
   end

   assign rob.alloc_ready_o      = alloc_rdy;
   assign rob.alloc_idx_o        = tail;
   assign rob.commit_valid_o     = commit;
   assign rob.commit_rd_o        = commit ? head_ent.rd : 5'd0;
   assign rob.commit_we_o        = commit && head_ent.we
                                && (head_ent.rd != 5'd0);
   assign rob.commit_result_o    = commit ? head_ent.result : 32'd0;
   assign rob.commit_store_o     = commit && head_ent.store;
   assign rob.commit_sb_idx_o    = commit ? head_ent.sb_idx : '0;
   assign rob.commit_kanata_id_o = commit ? head_ent.kanata_id : 32'd0;
   assign rob.flush_o            = flush;
   assign rob.flush_pc_o         = flush ? head_ent.new_pc : 32'd0;
   assign rob.count_o            = count_q;

   a_no_double_complete: assert property (
      @(posedge clk_i) disable iff (!rstn_i)
      (rob.complete_valid_i && ent_q[rob.complete_idx_i].valid)
      |-> !ent_q[rob.complete_idx_i].completed
   );

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed + random bench for rob_ctrl against a queue-based program-order model.
module tb_rob_ctrl;
   import rob_ctrl_pkg::*;

`ifdef ROB_FULL_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      int                idx;
      logic [4:0]        rd;
      logic              we;
      logic              st;
      store_buffer_idx_t sb;
      logic [31:0]       kid;
      bit                done;
      logic [31:0]       res;
      bit                bt;
      logic [31:0]       npc;
   } mrec_t;

   logic clk;
   logic rstn;
   int   n_total;
   int   n_pass;
   mrec_t q[$];
   int   next_idx;

   rob_ctrl_if rb ();

   rob_ctrl dut (
      .clk_i  (clk),
      .rstn_i (rstn),
      .rob    (rb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic set_idle();
      rb.alloc_valid_i           = 1'b0;
      rb.alloc_pc_i              = '0;
      rb.alloc_instr_i           = '0;
      rb.alloc_rd_i              = '0;
      rb.alloc_we_i              = 1'b0;
      rb.alloc_store_i           = 1'b0;
      rb.alloc_sb_idx_i          = '0;
      rb.alloc_kanata_id_i       = '0;
      rb.complete_valid_i        = 1'b0;
      rb.complete_idx_i          = '0;
      rb.complete_result_i       = '0;
      rb.complete_branch_taken_i = 1'b0;
      rb.complete_new_pc_i       = '0;
   endtask

   task automatic put_alloc(input logic [31:0] pc, input logic [4:0] rd,
                            input logic we, input logic st,
                            input int sb, input logic [31:0] kid);
      rb.alloc_valid_i     = 1'b1;
      rb.alloc_pc_i        = pc;
      rb.alloc_instr_i     = $urandom;
      rb.alloc_rd_i        = rd;
      rb.alloc_we_i        = we;
      rb.alloc_store_i     = st;
      rb.alloc_sb_idx_i    = store_buffer_idx_t'(sb);
      rb.alloc_kanata_id_i = kid;
   endtask

   task automatic put_alloc_rand();
      put_alloc($urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, STORE_BUFFER_SIZE - 1)), $urandom);
   endtask

   task automatic put_comp(input int idx, input logic [31:0] res,
                           input logic bt, input logic [31:0] npc);
      rb.complete_valid_i        = 1'b1;
      rb.complete_idx_i          = rob_idx_t'(idx);
      rb.complete_result_i       = res;
      rb.complete_branch_taken_i = bt;
      rb.complete_new_pc_i       = npc;
   endtask

   function automatic int pending_idx();
      int p[$];
      foreach (q[i]) if (!q[i].done) p.push_back(q[i].idx);
      if (p.size() == 0) return -1;
      return p[$urandom_range(0, p.size() - 1)];
   endfunction

   function automatic int free_idx();
      int f[$];
      bit used;
      for (int k = 0; k < ROB_SIZE; k++) begin
         used = 1'b0;
         foreach (q[i]) if (q[i].idx == k) used = 1'b1;
         if (!used) f.push_back(k);
      end
      if (f.size() == 0) return -1;
      return f[$urandom_range(0, f.size() - 1)];
   endfunction

   // one clock: predict and check at negedge, then advance the model
   task automatic cycle();
      bit    m_commit;
      bit    m_flush;
      bit    m_ready;
      bit    m_fire;
      mrec_t h;
      mrec_t n;
      @(negedge clk);
      m_commit = (q.size() > 0) && q[0].done;
      if (q.size() > 0) h = q[0];
      m_flush = m_commit && h.bt;
      m_ready = !m_flush && ((q.size() < ROB_SIZE) || (BYP && m_commit));
      m_fire  = rb.alloc_valid_i && m_ready;
      chk("alloc_ready", 32'(rb.alloc_ready_o), 32'(m_ready));
      chk("count", 32'(rb.count_o), q.size());
      chk("commit_valid", 32'(rb.commit_valid_o), 32'(m_commit));
      chk("flush", 32'(rb.flush_o), 32'(m_flush));
      chk("commit_we", 32'(rb.commit_we_o),
          32'(m_commit && h.we && (h.rd != 5'd0)));
      chk("commit_store", 32'(rb.commit_store_o), 32'(m_commit && h.st));
      if (m_fire)
         chk("alloc_idx", 32'(rb.alloc_idx_o), next_idx);
      if (m_commit) begin
         chk("commit_rd", 32'(rb.commit_rd_o), 32'(h.rd));
         chk("commit_result", rb.commit_result_o, h.res);
         chk("commit_sb", 32'(rb.commit_sb_idx_o), 32'(h.sb));
         chk("commit_kid", rb.commit_kanata_id_o, h.kid);
      end
      if (m_flush)
         chk("flush_pc", rb.flush_pc_o, h.npc);
      @(posedge clk);
      #1;
      if (m_flush) begin
         q.delete();
         next_idx = 0;
      end else begin
         if (rb.complete_valid_i)
            foreach (q[i])
               if (q[i].idx == int'(rb.complete_idx_i)) begin
                  q[i].done = 1'b1;
                  q[i].res  = rb.complete_result_i;
                  q[i].bt   = rb.complete_branch_taken_i;
                  q[i].npc  = rb.complete_new_pc_i;
               end
         if (m_commit) void'(q.pop_front());
         if (m_fire) begin
            n.idx  = next_idx;
            n.rd   = rb.alloc_rd_i;
            n.we   = rb.alloc_we_i;
            n.st   = rb.alloc_store_i;
            n.sb   = rb.alloc_sb_idx_i;
            n.kid  = rb.alloc_kanata_id_i;
            n.done = 1'b0;
            n.res  = '0;
            n.bt   = 1'b0;
            n.npc  = '0;
            q.push_back(n);
            next_idx = (next_idx + 1) % ROB_SIZE;
         end
      end
   endtask

   task automatic do_reset();
      set_idle();
      rstn = 1'b0;
      #2;
      chk("rst_ready", 32'(rb.alloc_ready_o), 0);
      chk("rst_count", 32'(rb.count_o), 0);
      chk("rst_commit", 32'(rb.commit_valid_o), 0);
      chk("rst_flush", 32'(rb.flush_o), 0);
      chk("rst_we", 32'(rb.commit_we_o), 0);
      chk("rst_store", 32'(rb.commit_store_o), 0);
      chk("rst_idx", 32'(rb.alloc_idx_o), 0);
      q.delete();
      next_idx = 0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic drain();
      int p;
      for (int k = 0; k < 80 && q.size() > 0; k++) begin
         set_idle();
         p = pending_idx();
         if (p >= 0) put_comp(p, $urandom, 1'b0, 32'd0);
         cycle();
      end
      chk("drained", 32'(rb.count_o), 0);
   endtask

   initial begin
      int p;
      n_total  = 0;
      n_pass   = 0;
      next_idx = 0;
      rstn     = 1'b0;
      set_idle();
      #1;
      do_reset();
      cycle();

      // in-order commit after out-of-order completion
      for (int i = 0; i < 3; i++) begin
         set_idle();
         put_alloc(32'(4 * i), 5'(i + 1), 1'b1, 1'b0, 0, 32'(100 + i));
         cycle();
      end
      set_idle(); put_comp(2, 32'hAAAA_0002, 1'b0, 0); cycle();
      set_idle(); put_comp(0, 32'hAAAA_0000, 1'b0, 0); cycle();
      set_idle(); put_comp(1, 32'hAAAA_0001, 1'b0, 0);
      #1 chk("t1_c0", rb.commit_result_o, 32'hAAAA_0000);
      cycle();
      set_idle();
      #1 chk("t1_c1", rb.commit_result_o, 32'hAAAA_0001);
      cycle();
      #1 chk("t1_c2", rb.commit_result_o, 32'hAAAA_0002);
      cycle();

      // full stall and full-slot reuse
      do_reset();
      for (int i = 0; i < ROB_SIZE; i++) begin
         set_idle(); put_alloc_rand(); cycle();
      end
      set_idle(); put_alloc_rand();
      #1 chk("full_count", 32'(rb.count_o), ROB_SIZE);
      chk("full_ready", 32'(rb.alloc_ready_o), 0);
      cycle();
      put_comp(0, 32'h55, 1'b0, 0);
      cycle();
      set_idle(); put_alloc_rand();
      #1 chk("commit_ready", 32'(rb.alloc_ready_o), 32'(BYP));
      chk("commit_idx", 32'(rb.alloc_idx_o), 0);
      cycle();
      #1 chk("after_ready", 32'(rb.alloc_ready_o), 32'(!BYP));
      cycle();
      drain();

      // branch flush, late completion ignored
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_idle(); put_alloc_rand(); cycle();
      end
      set_idle(); put_comp(1, 32'h11, 1'b1, 32'h100); cycle();
      set_idle(); put_comp(0, 32'h22, 1'b0, 0); cycle();
      set_idle(); cycle();
      #1 chk("br_flush", 32'(rb.flush_o), 1);
      chk("br_pc", rb.flush_pc_o, 32'h100);
      cycle();
      put_comp(2, 32'h33, 1'b0, 0); cycle();
      set_idle(); cycle(); cycle();
      chk("br_count", 32'(rb.count_o), 0);
      chk("br_late", 32'(rb.commit_valid_o), 0);

      // wrap-around
      do_reset();
      for (int i = 0; i < 20; i++) begin
         set_idle(); put_alloc_rand();
         #1 chk("wrap_idx", 32'(rb.alloc_idx_o), i % ROB_SIZE);
         cycle();
         set_idle(); put_comp(i % ROB_SIZE, $urandom, 1'b0, 0); cycle();
         set_idle(); cycle();
      end

      // x0 write suppression and store drain
      do_reset();
      set_idle(); put_alloc(32'h40, 5'd0, 1'b1, 1'b0, 0, 32'h7); cycle();
      set_idle(); put_alloc(32'h44, 5'd9, 1'b0, 1'b1, 3, 32'h8); cycle();
      set_idle(); put_comp(0, 32'h99, 1'b0, 0); cycle();
      set_idle(); put_comp(1, 32'h98, 1'b0, 0);
      #1 chk("x0_valid", 32'(rb.commit_valid_o), 1);
      chk("x0_we", 32'(rb.commit_we_o), 0);
      cycle();
      set_idle();
      #1 chk("st_store", 32'(rb.commit_store_o), 1);
      chk("st_sb", 32'(rb.commit_sb_idx_o), 3);
      cycle();

      // asynchronous reset with entries in flight
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_idle(); put_alloc_rand(); cycle();
      end
      set_idle(); put_comp(2, 32'h1, 1'b0, 0); cycle();
      set_idle(); put_comp(0, 32'h2, 1'b0, 0); cycle();
      set_idle();
      #1 chk("pre_rst_commit", 32'(rb.commit_valid_o), 1);
      do_reset();
      for (int i = 0; i < 3; i++) cycle();

      // random traffic
      do_reset();
      for (int c = 0; c < 600; c++) begin
         set_idle();
         if ($urandom_range(0, 9) < 6) put_alloc_rand();
         if ($urandom_range(0, 9) < 6) begin
            p = pending_idx();
            if (p >= 0 && $urandom_range(0, 7) != 0)
               put_comp(p, $urandom, 1'($urandom_range(0, 19) == 0),
                        $urandom);
            else begin
               p = free_idx();
               if (p >= 0) put_comp(p, $urandom, 1'b0, $urandom);
            end
         end
         cycle();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
In-order commit controller for the out-of-order completion backend. Holds ROB_SIZE rob_entry_t slots in a circular buffer.
- Allocates one entry per cycle at decode.
- Accepts one completion per cycle from WB.
- Retires one completed head entry per cycle to the register file and store buffer.
- Flushes everything younger when a committed instruction has branch_taken set.

Parameters:
ROB_SIZE, 16 (package localparam), number of entries; must be a power of 2, ≥2.
ROB_IDX_BITS, $clog2(ROB_SIZE), index width (rob_idx_t).

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
alloc_valid_i  in  1  decode requests an entry
alloc_ready_o  out  1  entry available this cycle
alloc_idx_o  out  ROB_IDX_BITS  index granted (tail pointer)
alloc_pc_i  in  32  instruction PC
alloc_instr_i  in  32  instruction_t
alloc_rd_i  in  5  destination register
alloc_we_i  in  1  writes rd
alloc_store_i  in  1  is a store
alloc_sb_idx_i  in  $clog2(STORE_BUFFER_SIZE)  store buffer slot
alloc_kanata_id_i  in  32  trace id
complete_valid_i  in  1  WB completion strobe
complete_idx_i  in  ROB_IDX_BITS  entry completing
complete_result_i  in  32  result value
complete_branch_taken_i  in  1  redirect required
complete_new_pc_i  in  32  redirect target
commit_valid_o  out  1  head retires this cycle
commit_rd_o  out  5  rd of retiring entry
commit_we_o  out  1  register write enable (commit_valid_o && write_enable && rd≠0)
commit_result_o  out  32  value to write
commit_store_o  out  1  drain store buffer slot
commit_sb_idx_o  out  $clog2(STORE_BUFFER_SIZE)  slot to drain
commit_kanata_id_o  out  32  trace id of retiring entry
flush_o  out  1  pipeline flush
flush_pc_o  out  32  fetch redirect PC
count_o  out  ROB_IDX_BITS+1  occupied entries

Behaviour:
- Reset (async, rstn_i=0):
  - head=tail=0, count=0.
  - All valid/completed bits 0.
  - All outputs 0, except alloc_ready_o=1 once reset is released.
- State: head, tail, count (ROB_IDX_BITS+1 bits); per-entry rob_entry_t. Pointers wrap modulo ROB_SIZE.
- Allocation:
  - alloc_ready_o = (count<ROB_SIZE) && !flush_o.
  - When alloc_valid_i && alloc_ready_o:
    - alloc_idx_o = tail.
    - Entry written with valid=1, completed=0, branch_taken=0.
    - tail++ at the clock edge.
- Completion:
  - When complete_valid_i and entry[complete_idx_i].valid, set completed=1 and latch result, branch_taken and new_pc at the edge.
  - Completion to an invalid entry is ignored.
  - Completion is visible to commit the next cycle at the earliest; there is no same-cycle bypass.
- Commit (combinational from head):
  - commit_valid_o = entry[head].valid && entry[head].completed.
  - When asserted: clear valid at head, head++ at the edge. One retirement per cycle.
- Flush:
  - flush_o = commit_valid_o && entry[head].branch_taken; flush_pc_o = entry[head].new_pc.
  - At the edge: all valid bits cleared, head=tail=0, count=0.
  - Allocations and completions in that cycle are discarded.
  - The branch itself still commits (commit_we_o for JAL/JALR link).
- count:
  - +1 on allocation, −1 on commit, unchanged on simultaneous allocation and commit.
  - Forced to 0 on flush.
- Full: count==ROB_SIZE → alloc_ready_o=0, even when commit_valid_o=1 in the same cycle (see the optional feature).
- Empty: count==0 → commit_valid_o=0 regardless of stale entry contents.
- Reset mid-operation: all in-flight entries are lost. No outputs assert until a new allocation has been completed.
- Assertion (simulation): complete_idx_i must not name an already-completed valid entry.

Optional Feature:
ROB_FULL_BYPASS_EN
- Defined: when full, alloc_ready_o = commit_valid_o && !flush_o. The freed head slot is reused in the same cycle; tail==head before the write, count stays ROB_SIZE.
- Undefined: strict full stall as above.

Decomposition:
- Shared package holds ROB_SIZE, ROB_IDX_BITS, rob_idx_t, rob_entry_t, store_buffer_idx_t and STORE_BUFFER_SIZE; none are redeclared locally.
- One natural sub-module, rob_ptr_ctr: wrap-around pointer with increment and synchronous clear. Instantiated twice, for head and tail.

Test Plan:
1. Reset, allocate 3 (pc 0x0,0x4,0x8), complete idx 2 then 0 then 1 → commits in order idx0,1,2 on consecutive cycles after idx0 completes; commit_result_o matches.
2. Allocate 16 without completion → count_o=16, alloc_ready_o=0; complete idx0, commit cycle → without macro alloc_ready_o stays 0 that cycle and is 1 the next; with ROB_FULL_BYPASS_EN it is 1 the same cycle and alloc_idx_o=0.
3. Allocate 4, complete idx1 with branch_taken=1, new_pc=0x100, then complete idx0 → idx0 commits, idx1 commits with flush_o=1, flush_pc_o=0x100; next cycle count_o=0, and a late completion to idx2 is ignored.
4. Wrap-around: 20 allocate/complete/commit pairs → alloc_idx_o sequence 0..15,0..3; count_o never exceeds 1.
5. Entry with rd=0, we=1 commits → commit_we_o=0; a store entry with sb_idx=3 → commit_store_o=1, commit_sb_idx_o=3.
6. Deassert rstn_i with 5 entries valid, some completed → outputs 0 asynchronously, count_o=0, alloc_ready_o=1 after release.
